// File: rtl/vx_ram_pkg.sv
// Shared helpers for the RAM primitives: address sizing, default word types and
// the byte-enable legality rule used by vx_dp_ram.
package vx_ram_pkg;

  // Smallest r with 2**r >= n, never less than 1 so a 1-entry index still has a bit.
  function automatic int log2up(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(n)) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Byte enables are either a single whole-word enable or one per 8-bit lane.
  function automatic bit byteen_legal(input int dataw, input int byteenw);
    return (byteenw == 1) || (((dataw % 8) == 0) && (byteenw == (dataw / 8)));
  endfunction

  localparam int DEF_DATAW = 8;
  localparam int DEF_SIZE  = 4;

  typedef logic [DEF_DATAW-1:0]        def_data_t;
  typedef logic [log2up(DEF_SIZE)-1:0] def_addr_t;
  typedef logic [7:0]                  lane_t;

endpackage

// File: rtl/vx_dp_ram_merge.sv
// Byte-lane merge: enabled lanes take the new data, disabled lanes keep the old word.
// BYTEENW==1 treats byteen_i[0] as a whole-word enable.
module vx_dp_ram_merge #(
  parameter int DATAW   = 8,
  parameter int BYTEENW = 1
) (
  input  logic [DATAW-1:0]   old_i,
  input  logic [DATAW-1:0]   new_i,
  input  logic [BYTEENW-1:0] byteen_i,
  output logic [DATAW-1:0]   merged_o
);

  generate
    if (BYTEENW == 1) begin : g_word
      assign merged_o = byteen_i[0] ? new_i : old_i;
    end else begin : g_lane
      for (genvar l = 0; l < BYTEENW; l++) begin : g_l
        assign merged_o[8*l +: 8] = byteen_i[l] ? new_i[8*l +: 8] : old_i[8*l +: 8];
      end
    end
  endgenerate

endmodule

// File: rtl/vx_dp_ram.sv
// Simple dual-port RAM (one write, one read port, one clock); FASTRAM selects a
// combinational or registered read. Define VX_DP_RAM_RESET_CLEAR_EN to clear contents on reset.
module vx_dp_ram
  import vx_ram_pkg::*;
#(
  parameter int DATAW   = 8,
  parameter int SIZE    = 4,
  parameter int BYTEENW = 1,
  parameter int RWCHECK = 0,
  parameter int FASTRAM = 0,
  localparam int ADDRW  = log2up(SIZE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDRW-1:0]   waddr,
  input  logic [ADDRW-1:0]   raddr,
  input  logic               wren,
  input  logic [BYTEENW-1:0] byteen,
  input  logic               rden,
  input  logic [DATAW-1:0]   din,
  output logic [DATAW-1:0]   dout
);

  localparam logic [ADDRW:0] SIZE_LIM = (ADDRW+1)'(SIZE);

  logic [DATAW-1:0] mem_q [SIZE];
  logic             waddr_ok;
  logic             raddr_ok;
  logic             wr_en;
  logic [DATAW-1:0] wr_old;
  logic [DATAW-1:0] wr_word;
  logic [DATAW-1:0] rd_word;

  generate
    if (!byteen_legal(DATAW, BYTEENW)) begin : g_bad_cfg
      $error("vx_dp_ram: BYTEENW must be 1 or DATAW/8");
    end
  endgenerate

  // Out-of-range addresses only exist for non-power-of-2 SIZE.
  assign waddr_ok = ({1'b0, waddr} < SIZE_LIM);
  assign raddr_ok = ({1'b0, raddr} < SIZE_LIM);
  assign wr_old   = waddr_ok ? mem_q[waddr] : '0;
  assign rd_word  = raddr_ok ? mem_q[raddr] : '0;
  assign wr_en    = wren && waddr_ok;

  vx_dp_ram_merge #(
    .DATAW   (DATAW),
    .BYTEENW (BYTEENW)
  ) u_merge (
    .old_i    (wr_old),
    .new_i    (din),
    .byteen_i (byteen),
    .merged_o (wr_word)
  );

`ifdef VX_DP_RAM_RESET_CLEAR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SIZE; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[waddr] <= wr_word;
    end
  end
`else
  // No reset on the array so it maps onto plain block/LUT RAM.
  always_ff @(posedge clk) begin
    if (reset && wr_en) mem_q[waddr] <= wr_word;
  end
`endif

  generate
    if (FASTRAM != 0) begin : g_fast
      logic unused_rden;
      assign unused_rden = rden;
      assign dout        = rd_word;
    end else begin : g_reg
      logic [DATAW-1:0] dout_d;
      logic [DATAW-1:0] dout_q;
      logic             bypass;

      // Write-first bypass returns the merged word that is about to land in memory.
      always_comb begin
        bypass = (RWCHECK != 0) && wren && rden && (waddr == raddr) && raddr_ok;
        dout_d = bypass ? wr_word : rd_word;
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          dout_q <= '0;
        end else if (rden) begin
          dout_q <= dout_d;
        end
      end

      assign dout = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_vx_dp_ram.sv
// Directed bench for vx_dp_ram: four instances cover fast read, write-first byte
// merge, read-first registered read and a non-power-of-2 depth.
module tb_vx_dp_ram;

`ifdef VX_DP_RAM_RESET_CLEAR_EN
  localparam bit CLEAR = 1'b1;
`else
  localparam bit CLEAR = 1'b0;
`endif

  logic clk;
  logic reset;

  // f: FASTRAM, 8b x 4
  logic [1:0] waddr_f, raddr_f;
  logic       wren_f, rden_f;
  logic [0:0] byteen_f;
  logic [7:0] din_f, dout_f;
  // b: registered, RWCHECK, 16b, two lanes
  logic [1:0]  waddr_b, raddr_b;
  logic        wren_b, rden_b;
  logic [1:0]  byteen_b;
  logic [15:0] din_b, dout_b;
  // r: registered, read-first, 8b x 4
  logic [1:0] waddr_r, raddr_r;
  logic       wren_r, rden_r;
  logic [0:0] byteen_r;
  logic [7:0] din_r, dout_r;
  // o: FASTRAM, 8b x 3
  logic [1:0] waddr_o, raddr_o;
  logic       wren_o, rden_o;
  logic [0:0] byteen_o;
  logic [7:0] din_o, dout_o;

  logic [15:0] exp_q[$];
  int          vectors;
  int          miscompares;
  logic [7:0]  f_pre [4];

  vx_dp_ram #(.DATAW(8), .SIZE(4), .BYTEENW(1), .RWCHECK(0), .FASTRAM(1)) u_f (
    .clk(clk), .reset(reset), .waddr(waddr_f), .raddr(raddr_f), .wren(wren_f),
    .byteen(byteen_f), .rden(rden_f), .din(din_f), .dout(dout_f));

  vx_dp_ram #(.DATAW(16), .SIZE(4), .BYTEENW(2), .RWCHECK(1), .FASTRAM(0)) u_b (
    .clk(clk), .reset(reset), .waddr(waddr_b), .raddr(raddr_b), .wren(wren_b),
    .byteen(byteen_b), .rden(rden_b), .din(din_b), .dout(dout_b));

  vx_dp_ram #(.DATAW(8), .SIZE(4), .BYTEENW(1), .RWCHECK(0), .FASTRAM(0)) u_r (
    .clk(clk), .reset(reset), .waddr(waddr_r), .raddr(raddr_r), .wren(wren_r),
    .byteen(byteen_r), .rden(rden_r), .din(din_r), .dout(dout_r));

  vx_dp_ram #(.DATAW(8), .SIZE(3), .BYTEENW(1), .RWCHECK(0), .FASTRAM(1)) u_o (
    .clk(clk), .reset(reset), .waddr(waddr_o), .raddr(raddr_o), .wren(wren_o),
    .byteen(byteen_o), .rden(rden_o), .din(din_o), .dout(dout_o));

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [15:0] obs);
    logic [15:0] exp;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: observed %h with empty scoreboard", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic write_r(input logic [1:0] a, input logic [7:0] d);
    wren_r = 1'b1; waddr_r = a; din_r = d; byteen_r = 1'b1;
    tick();
    wren_r = 1'b0;
  endtask

  task automatic read_r(input string tag, input logic [1:0] a, input logic [7:0] e);
    rden_r = 1'b1; raddr_r = a;
    push({8'h00, e});
    tick();
    rden_r = 1'b0;
    check(tag, {8'h00, dout_r});
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    {wren_f, rden_f, wren_b, rden_b, wren_r, rden_r, wren_o, rden_o} = '0;
    {waddr_f, raddr_f, waddr_b, raddr_b, waddr_r, raddr_r, waddr_o, raddr_o} = '0;
    byteen_f = 1'b1; byteen_b = 2'b11; byteen_r = 1'b1; byteen_o = 1'b1;
    din_f = '0; din_b = '0; din_r = '0; din_o = '0;
    f_pre[0] = 8'h01; f_pre[1] = 8'h21; f_pre[2] = 8'hA5; f_pre[3] = 8'h23;

    // Reset state
    tick(); tick();
    push(16'h0000); check("reset_dout_b", dout_b);
    push(16'h0000); check("reset_dout_r", {8'h00, dout_r});
    raddr_o = 2'd3; #1;
    push(16'h0000); check("reset_oob_o", {8'h00, dout_o});
    reset = 1'b1;
    tick();

    // Fast read: same-cycle write shows old data, new data after the edge
    wren_f = 1'b1; waddr_f = 2'd2; din_f = 8'h5A;
    tick();
    din_f = 8'hA5; raddr_f = 2'd2; #1;
    push(16'h005A); check("fast_same_cycle_old", {8'h00, dout_f});
    tick();
    wren_f = 1'b0; #1;
    push(16'h00A5); check("fast_after_edge", {8'h00, dout_f});
    wren_f = 1'b1; byteen_f = 1'b0; din_f = 8'hFF;
    tick();
    wren_f = 1'b0; byteen_f = 1'b1; #1;
    push(16'h00A5); check("fast_byteen0_nowrite", {8'h00, dout_f});
    for (int i = 0; i < 4; i++) begin
      if (i != 2) begin
        wren_f = 1'b1; waddr_f = 2'(i); din_f = f_pre[i];
        tick();
      end
    end
    wren_f = 1'b0; raddr_f = 2'd0; #1;
    push(16'h0001); check("fast_addr0", {8'h00, dout_f});

    // Write-first byte merge
    wren_b = 1'b1; waddr_b = 2'd1; din_b = 16'h1234; byteen_b = 2'b11;
    tick();
    din_b = 16'hABCD; byteen_b = 2'b01; rden_b = 1'b1; raddr_b = 2'd1;
    push(16'h12CD);
    tick();
    check("bypass_lane0", dout_b);
    din_b = 16'h5678; byteen_b = 2'b10;
    push(16'h56CD);
    tick();
    check("bypass_lane1", dout_b);
    wren_b = 1'b0;
    push(16'h56CD);
    tick();
    check("merged_in_mem", dout_b);
    rden_b = 1'b0;

    // Read-first on same address
    write_r(2'd3, 8'h11);
    wren_r = 1'b1; waddr_r = 2'd3; din_r = 8'h22;
    read_r("read_first_old", 2'd3, 8'h11);
    read_r("read_first_new", 2'd3, 8'h22);

    // rden=0 holds the registered output while memory changes
    write_r(2'd0, 8'h55);
    read_r("hold_setup", 2'd0, 8'h55);
    write_r(2'd0, 8'h66);
    tick();
    push(16'h0055); check("hold_rden0", {8'h00, dout_r});
    read_r("hold_mem_changed", 2'd0, 8'h66);

    // Sweep: write 0..3, read back in reverse
    for (int i = 0; i < 4; i++) write_r(2'(i), 8'h10 + 8'(i));
    for (int i = 3; i >= 0; i--) read_r("sweep_reverse", 2'(i), 8'h10 + 8'(i));

    // Write and read at different addresses in the same cycle
    wren_r = 1'b1; waddr_r = 2'd1; din_r = 8'h77;
    read_r("indep_read", 2'd2, 8'h12);
    read_r("indep_write", 2'd1, 8'h77);

    // Non-power-of-2 depth: address 3 is out of range
    wren_o = 1'b1; waddr_o = 2'd2; din_o = 8'h3C;
    tick();
    waddr_o = 2'd3; din_o = 8'h99;
    tick();
    wren_o = 1'b0; raddr_o = 2'd3; #1;
    push(16'h0000); check("oob_read_zero", {8'h00, dout_o});
    raddr_o = 2'd2; #1;
    push(16'h003C); check("oob_write_ignored", {8'h00, dout_o});

    // Mid-operation reset with a write in flight
    rden_r = 1'b1; raddr_r = 2'd0;
    tick();
    rden_r = 1'b0;
    wren_f = 1'b1; waddr_f = 2'd0; din_f = 8'hEE; byteen_f = 1'b1;
    reset = 1'b0; #1;
    push(16'h0000); check("async_reset_dout_b", dout_b);
    push(16'h0000); check("async_reset_dout_r", {8'h00, dout_r});
    tick();
    reset = 1'b1; wren_f = 1'b0;
    for (int i = 0; i < 4; i++) begin
      raddr_f = 2'(i); #1;
      push(CLEAR ? 16'h0000 : {8'h00, f_pre[i]});
      check("post_reset_fast", {8'h00, dout_f});
    end
    raddr_o = 2'd2; #1;
    push(CLEAR ? 16'h0000 : 16'h003C); check("post_reset_odd", {8'h00, dout_o});
    read_r("post_reset_reg", 2'd3, CLEAR ? 8'h00 : 8'h13);

    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
